// File: rtl/sync_pkg.sv
// Protocol constants shared by both ends of the host/peripheral serial link.
package sync_pkg;

  localparam int unsigned CmdWeBit   = 7;
  localparam int unsigned AdrWidth   = 4;
  localparam logic [7:0]  AckByte    = 8'h01;
  localparam logic [7:0]  WaitByte   = 8'h00;
  localparam logic [7:0]  FillerByte = 8'h00;

  // Command byte: write flag in the top bit, register address in the low bits.
  function automatic logic [7:0] cmd_byte(input logic we, input logic [AdrWidth-1:0] adr);
    logic [7:0] b;
    b = '0;
    b[CmdWeBit] = we;
    b[AdrWidth-1:0] = adr;
    return b;
  endfunction

endpackage

// File: rtl/host_sync.sv
// Serial-link initiator: turns one register request into a command/data/poll
// byte sequence with a single exchange outstanding at a time.
module host_sync
  import sync_pkg::*;
#(
  parameter int unsigned PollMax = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [AdrWidth-1:0] req_adr_i,
  input  logic [7:0]          req_dat_i,
  output logic                rsp_valid_o,
  output logic [7:0]          rsp_dat_o,
  output logic                rsp_err_o,
  output logic [7:0]          tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_valid_i
);

  typedef enum logic [2:0] {
    Idle,
    SendCmd,
    SendData,
    Poll,
    GetData,
    Respond
  } state_e;

  // The counter saturates at 255, so a larger limit is clamped to stay reachable.
  localparam logic [7:0] PollLimit = (PollMax > 255) ? 8'hFF : PollMax[7:0];

  state_e              state_reg, state_next;
  logic                outstanding_reg, outstanding_next;
  logic [7:0]          poll_cnt_reg, poll_cnt_next;
  logic [7:0]          rsp_dat_reg, rsp_dat_next;
  logic                rsp_err_reg, rsp_err_next;
  logic                we_reg;
  logic [AdrWidth-1:0] adr_reg;
  logic [7:0]          dat_reg;

  logic       tx_fire;
  logic       rx_fire;
  logic       accept;
  logic [7:0] poll_inc;

  assign tx_fire  = tx_valid_o && tx_ready_i;
  assign rx_fire  = rx_valid_i && outstanding_reg;
  assign accept   = req_valid_i && req_ready_o;
  assign poll_inc = (poll_cnt_reg == 8'hFF) ? 8'hFF : poll_cnt_reg + 8'd1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg       <= Idle;
      outstanding_reg <= 1'b0;
      poll_cnt_reg    <= '0;
      rsp_dat_reg     <= '0;
      rsp_err_reg     <= 1'b0;
      we_reg          <= 1'b0;
      adr_reg         <= '0;
      dat_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      outstanding_reg <= outstanding_next;
      poll_cnt_reg    <= poll_cnt_next;
      rsp_dat_reg     <= rsp_dat_next;
      rsp_err_reg     <= rsp_err_next;
      if (accept) begin
        we_reg  <= req_we_i;
        adr_reg <= req_adr_i;
        dat_reg <= req_dat_i;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    outstanding_next = outstanding_reg;
    poll_cnt_next    = poll_cnt_reg;
    rsp_dat_next     = rsp_dat_reg;
    rsp_err_next     = rsp_err_reg;

    // tx_valid_o is gated by outstanding_reg, so the two events never coincide.
    if (tx_fire) outstanding_next = 1'b1;
    if (rx_fire) outstanding_next = 1'b0;

    unique case (state_reg)
      Idle: begin
        if (accept) state_next = SendCmd;
      end
      SendCmd: begin
        if (rx_fire) begin
          state_next    = we_reg ? SendData : Poll;
          poll_cnt_next = '0;
        end
      end
      SendData: begin
        if (rx_fire) begin
          state_next    = Poll;
          poll_cnt_next = '0;
        end
      end
      Poll: begin
        if (rx_fire) begin
          if (rx_data_i == WaitByte) begin
            poll_cnt_next = poll_inc;
            if (poll_inc >= PollLimit) begin
              state_next   = Respond;
              rsp_err_next = 1'b1;
              rsp_dat_next = '0;
            end
          end else if (rx_data_i == AckByte) begin
            if (we_reg) begin
              state_next   = Respond;
              rsp_err_next = 1'b0;
              rsp_dat_next = '0;
            end else begin
              state_next = GetData;
            end
          end else begin
            state_next   = Respond;
            rsp_err_next = 1'b1;
            rsp_dat_next = '0;
          end
        end
      end
      GetData: begin
        if (rx_fire) begin
          state_next   = Respond;
          rsp_err_next = 1'b0;
          rsp_dat_next = rx_data_i;
        end
      end
      Respond: begin
        state_next = Idle;
      end
      default: begin
        state_next = Idle;
      end
    endcase
  end

  always_comb begin
    logic has_tx;
    has_tx      = 1'b0;
    tx_data_o   = '0;
    req_ready_o = rst_ni && (state_reg == Idle);
    rsp_valid_o = (state_reg == Respond);
    rsp_dat_o   = rsp_dat_reg;
    rsp_err_o   = rsp_err_reg;

    unique case (state_reg)
      SendCmd: begin
        has_tx    = 1'b1;
        tx_data_o = cmd_byte(we_reg, adr_reg);
      end
      SendData: begin
        has_tx    = 1'b1;
        tx_data_o = dat_reg;
      end
      Poll, GetData: begin
        has_tx    = 1'b1;
        tx_data_o = FillerByte;
      end
      default: begin
        has_tx    = 1'b0;
        tx_data_o = '0;
      end
    endcase

    tx_valid_o = has_tx && !outstanding_reg;
  end

endmodule

// File: tb/tb_host_sync.sv
// Randomized bench for host_sync: a reply-driven peer plus a transaction-level
// reference model of the byte sequence and response.
module tb_host_sync;
  import sync_pkg::*;

  localparam int unsigned PollMaxTb = 3;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_we_i = 1'b0;
  logic [3:0] req_adr_i = '0;
  logic [7:0] req_dat_i = '0;
  logic       tx_ready_i = 1'b0;
  logic [7:0] rx_data_i = '0;
  logic       rx_valid_i = 1'b0;
  logic       req_ready_o, rsp_valid_o, rsp_err_o, tx_valid_o;
  logic [7:0] rsp_dat_o, tx_data_o;

  int errors = 0;
  int checks = 0;
  int txn_no = 0;

  logic [7:0] reply_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] got_tx_q[$];
  logic       exp_err;
  logic [7:0] exp_dat;

  always #5 clk_i = ~clk_i;

  host_sync #(.PollMax(PollMaxTb)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_we_i   (req_we_i),
    .req_adr_i  (req_adr_i),
    .req_dat_i  (req_dat_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Replies listed first-to-last in the low n bytes of a packed word.
  task automatic set_replies(input logic [63:0] packed_r, input int n);
    reply_q.delete();
    for (int i = 0; i < n; i++) reply_q.push_back(packed_r[8*(n-1-i) +: 8]);
  endtask

  task automatic random_replies();
    reply_q.delete();
    reply_q.push_back(8'($urandom));
    reply_q.push_back(8'($urandom));
    for (int i = 0; i < 6; i++) begin
      case ($urandom % 4)
        0, 3:    reply_q.push_back(8'h00);
        1:       reply_q.push_back(8'h01);
        default: reply_q.push_back(8'($urandom_range(2, 255)));
      endcase
    end
  endtask

  // Transaction-level view: which bytes go out and what the response is.
  task automatic model(input logic we, input logic [3:0] adr, input logic [7:0] dat);
    int k;
    int zeros;
    bit done;
    logic [7:0] r;
    exp_tx_q.delete();
    exp_tx_q.push_back({we, 3'b000, adr});
    k = 1;
    if (we) begin
      exp_tx_q.push_back(dat);
      k = 2;
    end
    zeros = 0;
    done = 0;
    exp_err = 1'b0;
    exp_dat = 8'h00;
    while (!done && k < reply_q.size()) begin
      exp_tx_q.push_back(8'h00);
      r = reply_q[k];
      k++;
      if (r == 8'h00) begin
        zeros++;
        if (zeros >= PollMaxTb) begin
          exp_err = 1'b1;
          done = 1;
        end
      end else if (r == 8'h01) begin
        if (!we) begin
          exp_tx_q.push_back(8'h00);
          exp_dat = reply_q[k];
        end
        done = 1;
      end else begin
        exp_err = 1'b1;
        done = 1;
      end
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_req_ready"}, 32'(req_ready_o), 32'd0);
    check_val({pfx, "_tx_valid"}, 32'(tx_valid_o), 32'd0);
    check_val({pfx, "_tx_data"}, 32'(tx_data_o), 32'd0);
    check_val({pfx, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    check_val({pfx, "_rsp_dat"}, 32'(rsp_dat_o), 32'd0);
    check_val({pfx, "_rsp_err"}, 32'(rsp_err_o), 32'd0);
  endtask

  task automatic run_txn(input logic we, input logic [3:0] adr, input logic [7:0] dat,
                         input int stall_first, input bit spurious_en, input int abort_at);
    int pend, delay, ri, stall;
    bit held_v, seen_rsp;
    logic [7:0] held;
    logic got_err;
    logic [7:0] got_dat;
    bit rdy;
    model(we, adr, dat);
    got_tx_q.delete();
    pend = 0; delay = 0; ri = 0; stall = stall_first;
    held_v = 0; held = '0; seen_rsp = 0; got_err = 1'b0; got_dat = '0;
    txn_no++;

    check_val("idle_ready", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_adr_i = adr; req_dat_i = dat;
    step();
    req_valid_i = 1'b0;
    req_we_i = 1'($urandom); req_adr_i = 4'($urandom); req_dat_i = 8'($urandom);

    for (int cyc = 0; cyc < 400 && !seen_rsp; cyc++) begin
      if (abort_at > 0 && got_tx_q.size() == abort_at && pend != 0) begin
        rst_ni = 1'b0; rx_valid_i = 1'b0; tx_ready_i = 1'b0;
        step();
        check_reset_outputs("midrst");
        rst_ni = 1'b1; rx_valid_i = 1'b1; rx_data_i = 8'h01;
        step();
        rx_valid_i = 1'b0;
        check_val("postrst_ready", 32'(req_ready_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
          tx_ready_i = 1'($urandom);
          check_val("postrst_no_rsp", 32'(rsp_valid_o), 32'd0);
          check_val("postrst_no_tx", 32'(tx_valid_o), 32'd0);
          step();
        end
        tx_ready_i = 1'b0;
        $display("txn %0d we=%0d adr=%h dat=%h -> aborted by reset after %0d tx bytes",
                 txn_no, we, adr, dat, got_tx_q.size());
        return;
      end

      rx_valid_i = 1'b0;
      rx_data_i = 8'($urandom);
      if (rsp_valid_o) begin
        seen_rsp = 1;
        got_err = rsp_err_o;
        got_dat = rsp_dat_o;
        break;
      end
      if (pend != 0) check_val("one_outstanding", 32'(tx_valid_o), 32'd0);
      if (held_v) begin
        check_val("tx_valid_stable", 32'(tx_valid_o), 32'd1);
        check_val("tx_data_stable", 32'(tx_data_o), 32'(held));
      end

      if (pend != 0) begin
        if (delay == 0) begin
          rx_valid_i = 1'b1;
          rx_data_i = (ri < reply_q.size()) ? reply_q[ri] : 8'hEE;
          ri++;
          pend = 0;
        end else begin
          delay--;
        end
      end else if (spurious_en && ($urandom % 3 == 0)) begin
        rx_valid_i = 1'b1;
      end

      if (tx_valid_o) begin
        if (stall > 0) begin
          rdy = 1'b0;
          stall--;
        end else begin
          rdy = ($urandom % 4) != 0;
        end
        if (rdy) begin
          got_tx_q.push_back(tx_data_o);
          pend = 1;
          delay = $urandom % 3;
          held_v = 0;
        end else begin
          held_v = 1;
          held = tx_data_o;
        end
        tx_ready_i = rdy;
      end else begin
        tx_ready_i = 1'($urandom);
        held_v = 0;
      end
      step();
    end
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b0;

    if (!seen_rsp) check_val("rsp_timeout", 32'd0, 32'd1);
    check_val("tx_count", 32'(got_tx_q.size()), 32'(exp_tx_q.size()));
    for (int i = 0; i < got_tx_q.size() && i < exp_tx_q.size(); i++)
      check_val($sformatf("tx_byte%0d", i), 32'(got_tx_q[i]), 32'(exp_tx_q[i]));
    check_val("rsp_err", 32'(got_err), 32'(exp_err));
    check_val("rsp_dat", 32'(got_dat), 32'(exp_dat));

    step();
    check_val("rsp_one_cycle", 32'(rsp_valid_o), 32'd0);
    check_val("back_idle", 32'(req_ready_o), 32'd1);
    check_val("rsp_hold_dat", 32'(rsp_dat_o), 32'(exp_dat));
    check_val("rsp_hold_err", 32'(rsp_err_o), 32'(exp_err));
    $display("txn %0d we=%0d adr=%h dat=%h -> err=%0d rdat=%h tx_bytes=%0d",
             txn_no, we, adr, dat, got_err, got_dat, got_tx_q.size());
  endtask

  initial begin
    rst_ni = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    step();
    check_val("reset_release_ready", 32'(req_ready_o), 32'd1);

    // Write with immediate ack.
    set_replies(64'h3C_99_01, 3);
    run_txn(1'b1, 4'h3, 8'hA5, 0, 0, 0);
    // Read with two waits.
    set_replies(64'h11_00_00_01_5C, 5);
    run_txn(1'b0, 4'h7, 8'h00, 0, 0, 0);
    // Poll timeout on a write: data exchange plus three zero polls.
    set_replies(64'h21_22_00_00_00_00, 6);
    run_txn(1'b1, 4'h5, 8'h3C, 0, 0, 0);
    // Bad reply during Poll on a read.
    set_replies(64'h10_42, 2);
    run_txn(1'b0, 4'h2, 8'h00, 0, 0, 0);
    // Backpressure with spurious rx while nothing is outstanding.
    set_replies(64'h33_00_01_77, 4);
    run_txn(1'b0, 4'h9, 8'h00, 5, 1, 0);
    // Reset while the second poll is outstanding, then a normal transaction.
    set_replies(64'h00_00_00_00_00, 5);
    run_txn(1'b0, 4'h4, 8'h00, 0, 0, 3);
    set_replies(64'h44_55_01, 3);
    run_txn(1'b1, 4'hC, 8'h6E, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      random_replies();
      run_txn(1'($urandom), 4'($urandom), 8'($urandom),
              ($urandom % 4 == 0) ? int'($urandom_range(1, 5)) : 0, 1'b1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
